// File: rtl/evo_ctrl.sv
// evo_ctrl: generation timing and frame-buffer bank rotation for the
// Game-of-Life datapath. It turns button presses into run/pause/step/clear
// modes, paces generations with a speed-selectable period counter, drives a
// start/done/abort handshake to the evolution engine, and rotates the engine's
// read/write banks each time a generation completes.
module evo_ctrl #(
    parameter int unsigned BASE_PERIOD = 10000000,
    parameter int unsigned PERIOD_W    = 32,
    parameter int unsigned BANKS       = 2,
    parameter int unsigned BANK_W      = 3,
    parameter int unsigned GEN_W       = 16
) (
    input  logic              clk_vga,
    input  logic              reset_btn,
    input  logic              start_btn,
    input  logic              pause_btn,
    input  logic              step_btn,
    input  logic              clear_btn,
    input  logic [1:0]        speed_sel,
    input  logic              round_done,
    output logic              round_start,
    output logic              round_abort,
    output logic [BANK_W-1:0] rd_bank,
    output logic [BANK_W-1:0] wr_bank,
    output logic              vga_blank,
    output logic [1:0]        state,
    output logic              busy,
    output logic [GEN_W-1:0]  gen_count,
    output logic              overrun
);

    // Mode encoding is visible on the state output, so the values are fixed.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_STEP  = 2'd3;

    localparam logic [PERIOD_W-1:0] BASE_P    = PERIOD_W'(BASE_PERIOD);
    // A zero-length period would make the expiry compare underflow; never
    // let the counter period drop below one cycle.
    localparam logic [PERIOD_W-1:0] RESET_P   = (BASE_P == '0) ? PERIOD_W'(1) : BASE_P;
    localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(BANKS - 1);

    // Button index map: 0 clear, 1 pause, 2 start, 3 step.
    logic [3:0] btn_in;
    logic [3:0] btn_rise;

    assign btn_in = {step_btn, start_btn, pause_btn, clear_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic prev_reg;

            // Remember last cycle's button level so a held button fires once.
            always_ff @(posedge clk_vga or posedge reset_btn) begin
                if (reset_btn) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= btn_in[gi];
                end
            end

            assign btn_rise[gi] = btn_in[gi] & ~prev_reg;
        end
    endgenerate

    // Only the highest-priority event of a cycle survives:
    // clear > pause > start > step.
    logic ev_clear;
    logic ev_pause;
    logic ev_start;
    logic ev_step;

    assign ev_clear = btn_rise[0];
    assign ev_pause = btn_rise[1] & ~btn_rise[0];
    assign ev_start = btn_rise[2] & ~(|btn_rise[1:0]);
    assign ev_step  = btn_rise[3] & ~(|btn_rise[2:0]);

    // Registered state.
    logic [1:0]          state_reg,   state_next;
    logic [PERIOD_W-1:0] count_reg,   count_next;
    logic [PERIOD_W-1:0] period_reg,  period_next;
    logic                busy_reg,    busy_next;
    logic                start_reg,   start_next;
    logic                abort_reg,   abort_next;
    logic                overrun_reg, overrun_next;
    logic [GEN_W-1:0]    gen_reg,     gen_next;
    logic [BANK_W-1:0]   rd_reg,      rd_next;
    logic [BANK_W-1:0]   wr_reg,      wr_next;
    logic                blank_reg,   blank_next;

    // Period for the interval that starts at a reload.
    logic [PERIOD_W-1:0] period_shift;
    logic [PERIOD_W-1:0] period_sel;

    assign period_shift = BASE_P >> speed_sel;
    assign period_sel   = (period_shift == '0) ? PERIOD_W'(1) : period_shift;

    logic clear_act;
    logic done_acc;
    logic expire;

    // Clear is meaningful only outside IDLE; it also swallows any round_done
    // that arrives with it so a dropped generation never counts.
    assign clear_act = ev_clear && (state_reg != ST_IDLE);
    assign done_acc  = round_done && busy_reg && !clear_act;
    assign expire    = (state_reg == ST_RUN) && (count_reg == (period_reg - PERIOD_W'(1)));

    // Next-state logic: mode transitions, period pacing, handshake and rotation.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        period_next  = period_reg;
        busy_next    = busy_reg;
        start_next   = 1'b0;
        abort_next   = 1'b0;
        overrun_next = overrun_reg;
        gen_next     = gen_reg;
        rd_next      = rd_reg;
        wr_next      = wr_reg;
        blank_next   = blank_reg;

        if (clear_act) begin
            // Banks are left alone so the RAM contents survive a clear.
            state_next   = ST_IDLE;
            blank_next   = 1'b1;
            gen_next     = '0;
            count_next   = '0;
            overrun_next = 1'b0;
            busy_next    = 1'b0;
            abort_next   = busy_reg;
        end else begin
            if (done_acc) begin
                busy_next = 1'b0;
                rd_next   = wr_reg;
                wr_next   = (wr_reg == LAST_BANK) ? '0 : wr_reg + BANK_W'(1);
                gen_next  = gen_reg + GEN_W'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    count_next = '0;
                    if (ev_start) begin
                        state_next  = ST_RUN;
                        blank_next  = 1'b0;
                        period_next = period_sel;
                    end
                end
                ST_RUN: begin
                    if (expire) begin
                        count_next  = '0;
                        period_next = period_sel;
                        // A generation finishing on the expiry cycle frees
                        // the engine in time for the next one.
                        if (!busy_reg || done_acc) begin
                            start_next = 1'b1;
                            busy_next  = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        count_next = count_reg + PERIOD_W'(1);
                    end
                    if (ev_pause) begin
                        state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ev_start) begin
                        state_next = ST_RUN;
                    end else if (ev_step && !busy_reg) begin
                        state_next = ST_STEP;
                        start_next = 1'b1;
                        busy_next  = 1'b1;
                    end
                end
                ST_STEP: begin
                    if (done_acc) begin
                        state_next = ST_PAUSE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset returns every output to its idle value at once.
    always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            period_reg  <= RESET_P;
            busy_reg    <= 1'b0;
            start_reg   <= 1'b0;
            abort_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            gen_reg     <= '0;
            rd_reg      <= '0;
            wr_reg      <= BANK_W'(1);
            blank_reg   <= 1'b1;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            period_reg  <= period_next;
            busy_reg    <= busy_next;
            start_reg   <= start_next;
            abort_reg   <= abort_next;
            overrun_reg <= overrun_next;
            gen_reg     <= gen_next;
            rd_reg      <= rd_next;
            wr_reg      <= wr_next;
            blank_reg   <= blank_next;
        end
    end

    assign round_start = start_reg;
    assign round_abort = abort_reg;
    assign rd_bank     = rd_reg;
    assign wr_bank     = wr_reg;
    assign vga_blank   = blank_reg;
    assign state       = state_reg;
    assign busy        = busy_reg;
    assign gen_count   = gen_reg;
    assign overrun     = overrun_reg;

endmodule
